// File: rtl/conf_reg_bank_pkg.sv
// conf_reg_bank_pkg: shared CONF constants and commit state enum
package conf_reg_bank_pkg;
  localparam int C_ADDR_WIDTH = 8;
  localparam int C_DATA_WIDTH = 8;
  localparam int NUM_REGS = 16;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [C_ADDR_WIDTH-1:0] COMMIT_ADDR = 8'hFF;
  typedef enum logic {CONF_IDLE, CONF_COMMIT} conf_state_e;
endpackage

// File: rtl/conf_reg_bank.sv
// conf_reg_bank: CONF shadow/active register bank; c_addr/c_data/c_valid in, c_ready back-pressure, cfg_regs active view, cfg_update/addr_err pulses, busy during serial commit
module conf_reg_bank
  import conf_reg_bank_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_ADDR_WIDTH-1:0]          c_addr,
  input  logic [C_DATA_WIDTH-1:0]          c_data,
  input  logic                             c_valid,
  output logic                             c_ready,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0] cfg_regs,
  output logic                             cfg_update,
  output logic                             addr_err,
  output logic                             busy
);
  localparam logic [C_ADDR_WIDTH-1:0] N_A = C_ADDR_WIDTH'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
  conf_state_e state;
  logic [IDX_W-1:0] idx;
  logic [C_DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [C_DATA_WIDTH-1:0] active [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CONF_IDLE;
      c_ready <= 1'b0;
      busy <= 1'b0;
      cfg_update <= 1'b0;
      addr_err <= 1'b0;
      idx <= '0;
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      cfg_update <= 1'b0;
      addr_err <= 1'b0;
      if (state == CONF_IDLE) begin
        c_ready <= 1'b1;
        if (c_valid && c_ready) begin
          if (c_addr < N_A) shadow[c_addr[IDX_W-1:0]] <= c_data;
          else if (c_addr == COMMIT_ADDR) begin
            state <= CONF_COMMIT;
            idx <= '0;
            c_ready <= 1'b0;
            busy <= 1'b1;
          end else addr_err <= 1'b1;
        end
      end else begin
        active[idx] <= shadow[idx];
        if (idx == LAST) begin
          state <= CONF_IDLE;
          c_ready <= 1'b1;
          busy <= 1'b0;
          cfg_update <= 1'b1;
        end else idx <= idx + 1'b1;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
    assign cfg_regs[i*C_DATA_WIDTH +: C_DATA_WIDTH] = active[i];
  end
endmodule

// File: tb/tb_conf_reg_bank.sv
// tb_conf_reg_bank: randomized check of conf_reg_bank against a shadow/active array model
module tb_conf_reg_bank;
  import conf_reg_bank_pkg::*;
  localparam int W = NUM_REGS * C_DATA_WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [C_ADDR_WIDTH-1:0] c_addr = '0;
  logic [C_DATA_WIDTH-1:0] c_data = '0;
  logic c_valid = 1'b0;
  logic c_ready, cfg_update, addr_err, busy;
  logic [W-1:0] cfg_regs;
  int errs = 0;
  int checks = 0;
  logic [C_DATA_WIDTH-1:0] m_sh [NUM_REGS];
  logic [C_DATA_WIDTH-1:0] m_act [NUM_REGS];
  conf_reg_bank dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid),
    .c_ready(c_ready), .cfg_regs(cfg_regs), .cfg_update(cfg_update),
    .addr_err(addr_err), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // expected cfg_regs when the first k registers have been copied from shadow
  function automatic logic [W-1:0] view(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < NUM_REGS; j++)
      v[j*C_DATA_WIDTH +: C_DATA_WIDTH] = (j < k) ? m_sh[j] : m_act[j];
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear();
    for (int j = 0; j < NUM_REGS; j++) begin
      m_sh[j] = '0;
      m_act[j] = '0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    c_valid = 1'b0;
    repeat (3) begin
      step();
      check("rst_ready", W'(c_ready), '0);
      check("rst_busy", W'(busy), '0);
      check("rst_cfg", cfg_regs, '0);
    end
    model_clear();
    rst = 1'b0;
    step();
    check("rel_ready", W'(c_ready), W'(1'b1));
    check("rel_upd", W'(cfg_update), '0);
    check("rel_err", W'(addr_err), '0);
  endtask
  task automatic write(input int a, input int d);
    check("wr_pre_ready", W'(c_ready), W'(1'b1));
    c_addr = C_ADDR_WIDTH'(a);
    c_data = C_DATA_WIDTH'(d);
    c_valid = 1'b1;
    step();
    c_valid = 1'b0;
    if (a < NUM_REGS) m_sh[a] = C_DATA_WIDTH'(d);
    check("wr_err", W'(addr_err), W'(a >= NUM_REGS && a != int'(COMMIT_ADDR)));
    check("wr_cfg", cfg_regs, view(0));
    check("wr_ready", W'(c_ready), W'(1'b1));
    check("wr_busy", W'(busy), '0);
  endtask
  task automatic commit(input int abort_at, input bit hold, input int ha, input int hd);
    check("cm_pre_ready", W'(c_ready), W'(1'b1));
    c_addr = COMMIT_ADDR;
    c_valid = 1'b1;
    step();
    c_valid = hold;
    c_addr = C_ADDR_WIDTH'(ha);
    c_data = C_DATA_WIDTH'(hd);
    for (int k = 1; k <= NUM_REGS; k++) begin
      check("cm_busy", W'(busy), W'(1'b1));
      check("cm_ready", W'(c_ready), '0);
      check("cm_upd", W'(cfg_update), '0);
      check("cm_cfg", cfg_regs, view(k - 1));
      if (k == abort_at) begin
        rst = 1'b1;
        c_valid = 1'b0;
        step();
        model_clear();
        check("ab_cfg", cfg_regs, '0);
        check("ab_busy", W'(busy), '0);
        check("ab_upd", W'(cfg_update), '0);
        check("ab_ready", W'(c_ready), '0);
        rst = 1'b0;
        step();
        check("ab_rel_ready", W'(c_ready), W'(1'b1));
        check("ab_rel_upd", W'(cfg_update), '0);
        check("ab_rel_cfg", cfg_regs, '0);
        return;
      end
      step();
    end
    check("cm_done_upd", W'(cfg_update), W'(1'b1));
    check("cm_done_ready", W'(c_ready), W'(1'b1));
    check("cm_done_busy", W'(busy), '0);
    check("cm_done_cfg", cfg_regs, view(NUM_REGS));
    for (int j = 0; j < NUM_REGS; j++) m_act[j] = m_sh[j];
    step();
    c_valid = 1'b0;
    if (hold) m_sh[ha] = C_DATA_WIDTH'(hd);
    check("cm_post_upd", W'(cfg_update), '0);
    check("cm_post_cfg", cfg_regs, view(0));
    check("cm_post_ready", W'(c_ready), W'(1'b1));
  endtask
  initial begin
    model_clear();
    do_reset();
    write(3, 8'hA5);
    commit(0, 1'b0, 0, 0);
    write(5, 8'h11);
    write(5, 8'h22);
    commit(0, 1'b0, 0, 0);
    commit(0, 1'b1, 2, 8'h77);
    commit(0, 1'b0, 0, 0);
    write(8'h20, 8'h5A);
    write(0, 8'h01);
    write(NUM_REGS - 1, 8'hFE);
    write(NUM_REGS, 8'h33);
    commit(8, 1'b0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) write($urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255));
      else if (r < 8) write($urandom_range(NUM_REGS, 254), $urandom_range(0, 255));
      else if (r == 8)
        commit(($urandom_range(0, 7) == 0) ? $urandom_range(1, NUM_REGS) : 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255));
      else begin
        step();
        check("idle_cfg", cfg_regs, view(0));
        check("idle_err", W'(addr_err), '0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
